// File: rtl/gpio_apb_pkg.sv
// gpio_apb shared constants
// Register offsets (Paddr[3:2]) and reset values
package gpio_apb_pkg;

  localparam logic [1:0] GPIO_TX  = 2'd0;
  localparam logic [1:0] GPIO_DIR = 2'd1;
  localparam logic [1:0] GPIO_DSE = 2'd2;
  localparam logic [1:0] GPIO_RX  = 2'd3;

  localparam logic [7:0] TX_RST  = 8'h00;
  localparam logic [7:0] DIR_RST = 8'hFF;
  localparam logic [7:0] DSE_RST = 8'h00;

endpackage

// File: rtl/gpio_apb_if.sv
// APB slave bus bundle for gpio_apb
// Zero-wait-state APB, no slave error
interface gpio_apb_if;

  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [3:0]  strobe;
  logic [31:0] Prdata;
  logic        Pready;

  modport master (
    output Psel, Penable, Pwrite,
    output Paddr, Pwdata, strobe,
    input  Prdata, Pready
  );

  modport slave (
    input  Psel, Penable, Pwrite,
    input  Paddr, Pwdata, strobe,
    output Prdata, Pready
  );

endinterface

// File: rtl/gpio_apb_sync2.sv
// gpio_sync2: 8-bit two-flop input synchronizer
// Async active-low reset clears both stages
module gpio_sync2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta;

  // first stage may go metastable; second stage is the clean copy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 8'h00;
      q    <= 8'h00;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_apb.sv
// gpio_apb: 8-pin GPIO behind an APB slave port
// TX/DIR/DSE registers, synchronized RX readback
module gpio_apb
  import gpio_apb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  gpio_apb_if.slave  bus,
  input  logic [7:0] pindata,
  output logic [7:0] Rx,
  output logic [7:0] Tx,
  output logic [7:0] datanw,
  output logic [7:0] DSE
);

  logic [1:0] sel;
  logic       wr;
  logic [7:0] rd;
  logic       unused_bits;

  assign sel = bus.Paddr[3:2];
  assign wr  = bus.Psel & bus.Penable
             & bus.Pwrite & bus.strobe[0];

  assign bus.Pready = bus.Psel & bus.Penable;

  // upper address, byte offset and high lanes are don't-care
  assign unused_bits = ^{bus.Paddr[31:4],
                         bus.Paddr[1:0],
                         bus.Pwdata[31:8],
                         bus.strobe[3:1]};

  gpio_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (pindata),
    .q     (Rx)
  );

  // register file; RX offset silently drops writes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Tx     <= TX_RST;
      datanw <= DIR_RST;
      DSE    <= DSE_RST;
    end else if (wr) begin
      case (sel)
        GPIO_TX:  Tx     <= bus.Pwdata[7:0];
        GPIO_DIR: datanw <= bus.Pwdata[7:0];
        GPIO_DSE: DSE    <= bus.Pwdata[7:0];
        default:  ;
      endcase
    end
  end

  // read mux, live in both setup and access phases
  always_comb begin
    rd = 8'h00;
    case (sel)
      GPIO_TX:  rd = Tx;
      GPIO_DIR: rd = datanw;
      GPIO_DSE: rd = DSE;
      GPIO_RX:  rd = Rx;
      default:  rd = 8'h00;
    endcase
  end

  // drive read data only for selected reads
  always_comb begin
    bus.Prdata = 32'h0;
    if (bus.Psel && !bus.Pwrite)
      bus.Prdata = {24'h0, rd};
  end

endmodule

// File: tb/tb_gpio_apb.sv
// Self-checking bench for gpio_apb
// Directed scenarios plus random APB traffic vs a register model
module tb_gpio_apb;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pindata;
  logic [7:0] Rx, Tx, datanw, DSE;

  gpio_apb_if bus();

  gpio_apb dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .pindata (pindata),
    .Rx      (Rx),
    .Tx      (Tx),
    .datanw  (datanw),
    .DSE     (DSE)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // model: programmed registers and the settled pad value
  logic [7:0] m_tx, m_dir, m_dse, m_pin;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] v;
    case (a[3:2])
      2'd0:    v = m_tx;
      2'd1:    v = m_dir;
      2'd2:    v = m_dse;
      default: v = m_pin;
    endcase
    return {24'h0, v};
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0]  s);
    if (s[0]) begin
      if (a[3:2] == 2'd0) m_tx  = d[7:0];
      if (a[3:2] == 2'd1) m_dir = d[7:0];
      if (a[3:2] == 2'd2) m_dse = d[7:0];
    end
  endfunction

  function automatic void model_reset();
    m_tx  = 8'h00;
    m_dir = 8'hFF;
    m_dse = 8'h00;
  endfunction

  task automatic bus_idle();
    bus.Psel    = 1'b0;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = 32'h0;
    bus.Pwdata  = 32'h0;
    bus.strobe  = 4'h0;
  endtask

  task automatic apb_write(input  logic [31:0] a,
                           input  logic [31:0] d,
                           input  logic [3:0]  s,
                           output logic        rdy);
    @(negedge clock);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = a;
    bus.Pwdata  = d;
    bus.strobe  = s;
    @(negedge clock);
    bus.Penable = 1'b1;
    #1 rdy = bus.Pready;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic apb_read(input  logic [31:0] a,
                          output logic [31:0] rs,
                          output logic [31:0] ra);
    @(negedge clock);
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = a;
    bus.Pwdata  = $urandom;
    bus.strobe  = 4'($urandom);
    #1 rs = bus.Prdata;
    @(negedge clock);
    bus.Penable = 1'b1;
    #1 ra = bus.Prdata;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic test_reset();
    logic rdy;
    reset = 1'b1;
    apb_write(32'h0, 32'hAA, 4'h1, rdy);
    apb_write(32'h4, 32'h00, 4'h1, rdy);
    apb_write(32'h8, 32'hFF, 4'h1, rdy);
    pindata = 8'h3C;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Tx, datanw, DSE, Rx} !== 32'h00FF_0000) begin
      errors++;
      $display("FAIL reset_async pins=%h want 00ff0000",
               {Tx, datanw, DSE, Rx});
    end
    checks++;
    if (bus.Prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_prdata got=%h want 0", bus.Prdata);
    end
    @(negedge clock);
    pindata = 8'h00;
    reset = 1'b1;
    model_reset();
    m_pin = 8'h00;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write_tx();
    logic        rdy;
    logic [31:0] rs, ra;
    apb_write(32'h348cf010, 32'h4567abcf, 4'h1, rdy);
    model_write(32'h348cf010, 32'h4567abcf, 4'h1);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL tx_pready got=%b want 1", rdy);
    end
    checks++;
    if (Tx !== 8'hCF) begin
      errors++;
      $display("FAIL tx_pin got=%h want cf", Tx);
    end
    apb_read(32'h0, rs, ra);
    checks++;
    if (rs !== 32'hCF || ra !== 32'hCF) begin
      errors++;
      $display("FAIL tx_readback got=%h/%h want cf", rs, ra);
    end
  endtask

  task automatic test_alias();
    logic rdy;
    apb_write(32'h34, 32'h2a, 4'h1, rdy);
    model_write(32'h34, 32'h2a, 4'h1);
    checks++;
    if (datanw !== 8'h2A) begin
      errors++;
      $display("FAIL dir_alias got=%h want 2a", datanw);
    end
    apb_write(32'h3a, 32'h55, 4'h1, rdy);
    model_write(32'h3a, 32'h55, 4'h1);
    checks++;
    if (DSE !== 8'h55) begin
      errors++;
      $display("FAIL dse_alias got=%h want 55", DSE);
    end
    apb_write(32'h3a, 32'h77, 4'h0, rdy);
    checks++;
    if (DSE !== 8'h55) begin
      errors++;
      $display("FAIL dse_nostrobe got=%h want 55", DSE);
    end
  endtask

  task automatic test_input();
    logic        rdy;
    logic [31:0] rs, ra;
    @(negedge clock);
    pindata = 8'hB5;
    @(posedge clock);
    #1;
    checks++;
    if (Rx !== m_pin) begin
      errors++;
      $display("FAIL rx_one_edge got=%h want %h", Rx, m_pin);
    end
    @(posedge clock);
    #1;
    m_pin = 8'hB5;
    checks++;
    if (Rx !== 8'hB5) begin
      errors++;
      $display("FAIL rx_two_edges got=%h want b5", Rx);
    end
    apb_read(32'h0abcfdef, rs, ra);
    checks++;
    if (rs !== 32'hB5 || ra !== 32'hB5) begin
      errors++;
      $display("FAIL rx_read got=%h/%h want b5", rs, ra);
    end
    apb_write(32'hC, 32'hFF, 4'hF, rdy);
    checks++;
    if (rdy !== 1'b1 ||
        {Tx, datanw, DSE, Rx} !== {m_tx, m_dir, m_dse, m_pin}) begin
      errors++;
      $display("FAIL rx_write_ignored rdy=%b pins=%h want 1 %h", rdy,
               {Tx, datanw, DSE, Rx}, {m_tx, m_dir, m_dse, m_pin});
    end
  endtask

  task automatic test_protocol();
    @(negedge clock);
    bus.Psel    = 1'b0;
    bus.Penable = 1'b1;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 32'h0;
    bus.Pwdata  = 32'hFF;
    bus.strobe  = 4'hF;
    #1;
    checks++;
    if (bus.Pready !== 1'b0 || bus.Prdata !== 32'h0) begin
      errors++;
      $display("FAIL nosel_bus pready=%b prdata=%h want 0 0",
               bus.Pready, bus.Prdata);
    end
    @(negedge clock);
    checks++;
    if ({Tx, datanw, DSE} !== {m_tx, m_dir, m_dse}) begin
      errors++;
      $display("FAIL nosel_regs got=%h want %h",
               {Tx, datanw, DSE}, {m_tx, m_dir, m_dse});
    end
    bus.Psel    = 1'b1;
    bus.Penable = 1'b0;
    bus.Paddr   = 32'h4;
    bus.Pwdata  = 32'h11;
    bus.strobe  = 4'h1;
    @(negedge clock);
    bus.Penable = 1'b1;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    checks++;
    if ({Tx, datanw, DSE, Rx} !== 32'h00FF_0000) begin
      errors++;
      $display("FAIL reset_in_access got=%h want 00ff0000",
               {Tx, datanw, DSE, Rx});
    end
    @(negedge clock);
    bus_idle();
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_random();
    logic        rdy;
    logic [31:0] a, d, rs, ra;
    logic [3:0]  s;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        pindata = 8'($urandom);
        apb_write(a, d, s, rdy);
        m_pin = pindata;
        model_write(a, d, s);
        checks++;
        if (rdy !== 1'b1 ||
            {Tx, datanw, DSE, Rx} !== {m_tx, m_dir, m_dse, m_pin}) begin
          errors++;
          $display("FAIL rand_write i=%0d a=%h rdy=%b got=%h want %h",
                   i, a, rdy, {Tx, datanw, DSE, Rx},
                   {m_tx, m_dir, m_dse, m_pin});
        end
      end else begin
        apb_read(a, rs, ra);
        checks++;
        if (rs !== exp_read(a) || ra !== exp_read(a)) begin
          errors++;
          $display("FAIL rand_read i=%0d a=%h got=%h/%h want %h",
                   i, a, rs, ra, exp_read(a));
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    pindata = 8'h00;
    bus_idle();
    model_reset();
    m_pin = 8'h00;
    repeat (2) @(negedge clock);
    test_reset();
    test_write_tx();
    test_alias();
    test_input();
    test_protocol();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
